det_recip: RTL and testbench
============================

Name: det_recip

Overview:
- Sequential fixed-point reciprocal unit. It sits directly downstream of the matdetN determinant blocks.
- It takes one signed determinant word and returns 1/det in the same fixed-point format, plus singular and overflow flags.
- The next stage (adjugate scaling for matrix inversion) consumes its output.
- It uses an iterative restoring divider, one quotient bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 16, total word width; signed two's complement.
- BIN_POS, 8, number of fractional bits; 0 <= BIN_POS < DATA_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  det is valid.
- in_ready  out  1  block can accept a det.
- det  in  DATA_WIDTH  signed fixed-point determinant.
- out_valid  out  1  recip and flags are valid.
- out_ready  in  1  downstream accepts the result.
- recip  out  DATA_WIDTH  signed fixed-point 1/det.
- singular  out  1  det was zero.
- overflow  out  1  magnitude was saturated.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; in_ready=1; out_valid=0; recip=0; singular=0; overflow=0; internal registers cleared.
  - Reset mid-DIVIDE or mid-HOLD aborts silently; the pending result is lost.
- States: IDLE, DIVIDE, FIXUP, HOLD.
- IDLE:
  - in_ready=1 (registered, equal to state==IDLE).
  - On in_valid, latch sign=det[MSB] and mag=|det| as an unsigned DATA_WIDTH value (0x8000 gives 32768).
  - If det==0: go to HOLD with recip=2^(DATA_WIDTH-1)-1, singular=1, overflow=0.
  - Otherwise: go to DIVIDE. Dividend N=1<<(2*BIN_POS), 2*DATA_WIDTH bits wide. Clear quotient and remainder; counter=2*DATA_WIDTH-1.
- DIVIDE (one iteration per cycle, MSB first, restoring):
  - rem={rem,N[counter]}.
  - If rem>=mag, subtract mag and set q bit to 1.
  - After the counter reaches 0, go to FIXUP.
  - Exactly 2*DATA_WIDTH cycles.
- FIXUP:
  - Quotient q = floor(N/|det|), truncation toward zero.
  - Positive result: if q > 2^(DATA_WIDTH-1)-1, recip=0x7FF..F and overflow=1.
  - Negative result: if q > 2^(DATA_WIDTH-1), recip=0x800..0 and overflow=1; otherwise recip=-q.
  - singular=0. Go to HOLD.
- HOLD:
  - out_valid=1. recip and flags are stable until the handshake.
  - When out_ready=1 at an edge, out_valid falls and state returns to IDLE.
  - No new input is accepted in the same cycle; in_ready rises the cycle after.
- Latency:
  - det accepted at edge t gives out_valid high after edge t+2*DATA_WIDTH+1 (34 cycles for W=16).
  - Singular case: out_valid high after edge t, i.e. 1 cycle.
- Ordering rules:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside HOLD.
  - det may change freely after acceptance.
- Throughput: one result per 2*DATA_WIDTH+3 cycles, given immediate out_ready.

Decomposition:
- Shared package det_pkg holds:
  - the state enum (IDLE, DIVIDE, FIXUP, HOLD);
  - constant functions MAX_POS(W) and MIN_NEG(W);
  - ONE(W,BP)=1<<BP.
- One natural sub-module: udiv_iter, an unsigned iterative restoring divider.
  - Parameterised by dividend and divisor widths.
  - Ports: start, busy, done.
  - det_recip keeps the handshake, sign handling and saturation.

Test Plan (DATA_WIDTH=16, BIN_POS=8, out_ready=1 unless stated):
- Unit and power of two: det=0x0100 gives recip=0x0100. det=0x0200 gives recip=0x0080. Both flags 0; out_valid exactly 34 cycles after acceptance.
- Negative and truncation: det=0xFC00 (-4.0) gives recip=0xFFC0. det=0x0300 (3.0) gives recip=0x0055, since 65536/768=85.33 truncates to 85.
- Singular and saturation:
  - det=0x0000 gives recip=0x7FFF, singular=1, out_valid 1 cycle after acceptance.
  - det=0x0001 gives recip=0x7FFF, overflow=1.
  - det=0xFFFF gives recip=0x8000, overflow=1.
  - det=0x8000 gives recip=0xFFFE, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD. recip must be stable, out_valid=1, in_ready=0, and in_valid pulses must be ignored. Releasing out_ready returns to IDLE; in_ready=1 the next cycle.
- Reset mid-operation: assert rst 5 cycles into DIVIDE. The next cycle must show out_valid=0 and in_ready=1. A following det=0x0200 must give a clean 0x0080.
- Random sweep: 200 seeded random dets (value%10<<<8 plus random raw words), checked against a reference model floor(65536/|det|) with sign and saturation applied.

Source files
------------

// File: rtl/det_pkg.sv
// Shared types and fixed-point constants for the determinant reciprocal path.
package det_pkg;

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, HOLD} state_t;

  // Largest positive two's complement value of width w.
  function automatic logic [63:0] MAX_POS(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative value of width w (magnitude 2^(w-1)).
  function automatic logic [63:0] MIN_NEG(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Fixed-point 1.0 with bp fractional bits; zero if it cannot fit in w bits.
  function automatic logic [63:0] ONE(input int w, input int bp);
    return (bp < w) ? (64'd1 << bp) : 64'd0;
  endfunction

endpackage

// File: rtl/det_recip_udiv_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
module udiv_iter #(
  parameter int NW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quot
);
  localparam int CW = $clog2(NW);

  logic [NW-1:0] n_q;
  logic [DW-1:0] d_q;
  logic [DW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [DW:0]   rem_sh;
  logic          ge;

  assign rem_sh = {rem, n_q[cnt]};
  assign ge     = rem_sh >= {1'b0, d_q};
  // done flags the cycle doing the final iteration; quot is complete after it
  assign done   = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      n_q  <= '0;
      d_q  <= '0;
      rem  <= '0;
      quot <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CW'(NW - 1);
      n_q  <= dividend;
      d_q  <= divisor;
      rem  <= '0;
      quot <= '0;
    end else if (busy) begin
      rem  <= ge ? DW'(rem_sh - {1'b0, d_q}) : rem_sh[DW-1:0];
      quot <= {quot[NW-2:0], ge};
      cnt  <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/det_recip.sv
// Fixed-point reciprocal of a signed determinant with singular/overflow flags.
module det_recip
  import det_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BIN_POS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] det,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] recip,
  output logic                  singular,
  output logic                  overflow
);
  localparam int W  = DATA_WIDTH;
  localparam int NW = 2 * DATA_WIDTH;
  localparam logic [NW-1:0] NUM  = NW'(ONE(NW, 2 * BIN_POS));
  localparam logic [W-1:0]  RMAX = W'(MAX_POS(W));
  localparam logic [W-1:0]  RMIN = W'(MIN_NEG(W));
  localparam logic [NW-1:0] QMAX = NW'(MAX_POS(W));
  localparam logic [NW-1:0] QMIN = NW'(MIN_NEG(W));

  state_t        state, nxt;
  logic          sign;
  logic [W-1:0]  mag;
  logic          start, div_busy, div_done;
  logic [NW-1:0] quot;

  // -0x80..0 wraps to 0x80..0, which is the correct unsigned magnitude
  assign mag       = det[W-1] ? (~det + 1'b1) : det;
  assign start     = (state == IDLE) && in_valid && (det != '0);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  udiv_iter #(.NW(NW), .DW(W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (NUM),
    .divisor  (mag),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (quot)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = (det == '0) ? HOLD : DIVIDE;
      DIVIDE:  if (div_done || !div_busy) nxt = FIXUP;
      FIXUP:   nxt = HOLD;
      HOLD:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign     <= 1'b0;
      recip    <= '0;
      singular <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= det[W-1];
          if (det == '0) begin
            recip    <= RMAX;
            singular <= 1'b1;
            overflow <= 1'b0;
          end
        end
        FIXUP: begin
          singular <= 1'b0;
          if (!sign) begin
            if (quot > QMAX) begin
              recip    <= RMAX;
              overflow <= 1'b1;
            end else begin
              recip    <= quot[W-1:0];
              overflow <= 1'b0;
            end
          end else begin
            // q == 2^(W-1) negates exactly to the most negative value
            if (quot > QMIN) begin
              recip    <= RMIN;
              overflow <= 1'b1;
            end else begin
              recip    <= ~quot[W-1:0] + 1'b1;
              overflow <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det_recip.sv
// Directed and random checks of det_recip against an integer reciprocal model.
module tb_det_recip;
  localparam int W  = 16;
  localparam int BP = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] det;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] recip;
  logic         singular;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  det_recip #(.DATA_WIDTH(W), .BIN_POS(BP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .det       (det),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .recip     (recip),
    .singular  (singular),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: floor(2^(2*BP)/|d|), signed, clamped to the W-bit range.
  task automatic model(input logic [W-1:0] d, output logic [W-1:0] r,
                       output logic s, output logic o);
    longint v, m, q, val;
    v = longint'($signed(d));
    s = 1'b0;
    o = 1'b0;
    if (v == 0) begin
      r = 16'h7FFF;
      s = 1'b1;
    end else begin
      m   = (v < 0) ? -v : v;
      q   = (longint'(1) << (2 * BP)) / m;
      val = (v < 0) ? -q : q;
      if (val > 32767) begin
        r = 16'h7FFF; o = 1'b1;
      end else if (val < -32768) begin
        r = 16'h8000; o = 1'b1;
      end else begin
        r = W'(val);
      end
    end
  endtask

  // Latency counts the acceptance edge: 34 edges normally, 1 for singular.
  task automatic xact(input string tag, input logic [W-1:0] d, input logic [W-1:0] er,
                      input logic es, input logic eo);
    int lat;
    lat = 0;
    while (!in_ready && lat < 100) begin step(); lat++; end
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    det       = d;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    det      = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    chk({tag, "_lat"}, 32'(lat), es ? 32'd1 : 32'd34);
    chk({tag, "_recip"}, {16'd0, recip}, {16'd0, er});
    chk({tag, "_flags"}, {30'd0, singular, overflow}, {30'd0, es, eo});
    step();
    chk({tag, "_ack"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] d, er;
    logic es, eo;
    int lat;
    void'($urandom(32'h1234));
    rst = 1'b1; in_valid = 1'b0; det = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_recip", {16'd0, recip}, 32'd0);
    chk("rst_flags", {30'd0, singular, overflow}, 32'd0);

    xact("unit",  16'h0100, 16'h0100, 1'b0, 1'b0);
    xact("half",  16'h0200, 16'h0080, 1'b0, 1'b0);
    xact("neg4",  16'hFC00, 16'hFFC0, 1'b0, 1'b0);
    xact("three", 16'h0300, 16'h0055, 1'b0, 1'b0);
    xact("zero",  16'h0000, 16'h7FFF, 1'b1, 1'b0);
    xact("tiny",  16'h0001, 16'h7FFF, 1'b0, 1'b1);
    xact("ntiny", 16'hFFFF, 16'h8000, 1'b0, 1'b1);
    xact("minneg",16'h8000, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure in HOLD with ignored input pulses
    in_valid = 1'b1; det = 16'h0300; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin step(); lat++; end
    chk("bp_lat", 32'(lat), 32'd34);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      det      = W'($urandom);
      step();
      chk("bp_recip", {16'd0, recip}, 32'h55);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset five cycles into DIVIDE
    in_valid = 1'b1; det = 16'h0100;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    xact("post_rst", 16'h0200, 16'h0080, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        int v;
        v = int'($urandom % 19) - 9;
        d = W'(v <<< 8);
      end else begin
        d = W'($urandom);
      end
      model(d, er, es, eo);
      xact("rand", d, er, es, eo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
